// File: rtl/warmboot_pkg.sv
// Shared types and boot-table field positions for the warm-boot sequencer.
package warmboot_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StDecode,
        StCount,
        StArm,
        StFire,
        StHalt
    } state_t;

    // Boot-table word layout: [15] valid, [14:13] {S1,S0}, [12:0] dwell ticks
    localparam int unsigned VALID_BIT = 15;
    localparam int unsigned SEL_HI    = 14;
    localparam int unsigned SEL_LO    = 13;
    localparam int unsigned DWELL_W   = 13;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every TICK_CYCLES enabled cycles.
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 48_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = $clog2(TICK_CYCLES);
    localparam logic [CntW-1:0] LastCnt = CntW'(TICK_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == LastCnt);

    // Next count: clear wins, otherwise wrap at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/warmboot_scheduler.sv
// Fetches the boot-table word from BRAM, counts the dwell, then arms and fires SB_WARMBOOT.
module warmboot_scheduler
    import warmboot_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 8,
    parameter logic [ADDR_W-1:0]  CFG_ADDR    = 8'd1,
    parameter int unsigned        TICK_CYCLES = 48_000_000,
    parameter int unsigned        ARM_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    input  logic              boot_req,
    input  logic              abort,
    output logic              wb_s1,
    output logic              wb_s0,
    output logic              wb_boot,
    output logic              busy,
    output logic              err
);

    localparam int unsigned ArmW = $clog2(ARM_CYCLES + 1);
    localparam logic [ArmW-1:0] ArmLast = ArmW'(ARM_CYCLES - 1);

    state_t state_q, state_d;
    // Reset parks in FETCH with rd_en low; the first edge re-enters FETCH to issue the read
    logic primed_q;

    logic [1:0]         sel_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [ArmW-1:0]    arm_cnt_q, arm_cnt_d;

    logic tick, in_count, dwell_done, arm_done;
    logic rd_en_d, wb_s1_d, wb_s0_d, wb_boot_d, busy_d, err_d;

    assign rd_addr  = CFG_ADDR;
    assign in_count = (state_q == StCount);

    (* keep_hierarchy *)
    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_count),
        .en    (in_count),
        .tick  (tick)
    );

    // Dwell expires on the tick that brings the counter up to the latched dwell
    assign dwell_done = tick && (dwell_q != '0) && ((dwell_cnt_q + DWELL_W'(1)) == dwell_q);
    assign arm_done   = (arm_cnt_q == ArmLast);

    // Dwell and arm counters; both clear whenever their state is left
    always_comb begin
        dwell_cnt_d = dwell_cnt_q;
        if (!in_count) begin
            dwell_cnt_d = '0;
        end else if (tick && (dwell_cnt_q < dwell_q)) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
        arm_cnt_d = (state_q == StArm) ? arm_cnt_q + ArmW'(1) : '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            primed_q <= 1'b1;
        end
    end

    // Next-state logic; abort beats boot_req
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = primed_q ? StWait : StFetch;
            StWait:   state_d = StDecode;
            StDecode: state_d = rd_data[VALID_BIT] ? StCount : StHalt;
            StCount: begin
                if (abort) begin
                    state_d = StFetch;
                end else if (boot_req || dwell_done) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (abort) begin
                    state_d = StFetch;
                end else if (arm_done) begin
                    state_d = StFire;
                end
            end
            StFire:   state_d = StFire;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // Output next values; select lines only move on ARM entry or on return to FETCH
    always_comb begin
        rd_en_d   = (state_d == StFetch);
        wb_boot_d = (state_d == StFire);
        busy_d    = (state_d != StHalt);
        err_d     = (state_d == StHalt);
        wb_s1_d   = wb_s1;
        wb_s0_d   = wb_s0;
        if (state_d == StFetch) begin
            wb_s1_d = 1'b0;
            wb_s0_d = 1'b0;
        end else if ((state_d == StArm) && (state_q != StArm)) begin
            wb_s1_d = sel_q[1];
            wb_s0_d = sel_q[0];
        end
    end

    // Registered outputs, latched table fields and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en       <= 1'b0;
            wb_s1       <= 1'b0;
            wb_s0       <= 1'b0;
            wb_boot     <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            sel_q       <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            arm_cnt_q   <= '0;
        end else begin
            rd_en       <= rd_en_d;
            wb_s1       <= wb_s1_d;
            wb_s0       <= wb_s0_d;
            wb_boot     <= wb_boot_d;
            busy        <= busy_d;
            err         <= err_d;
            dwell_cnt_q <= dwell_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            if (state_q == StDecode) begin
                sel_q   <= rd_data[SEL_HI:SEL_LO];
                dwell_q <= rd_data[DWELL_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_warmboot_scheduler.sv
// Directed bench for warmboot_scheduler with a 1-cycle-latency BRAM model and boot scoreboard.
module tb_warmboot_scheduler;

    localparam int unsigned TICK = 4;
    localparam int unsigned ARM  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data = '0;
    logic [15:0] bram_word = '0;
    logic        boot_req = 1'b0;
    logic        abort = 1'b0;
    logic        wb_s1, wb_s0, wb_boot, busy, err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   boot_cyc;
        logic s1;
        logic s0;
    } exp_t;
    exp_t sb[$];

    warmboot_scheduler #(
        .ADDR_W      (8),
        .CFG_ADDR    (8'd1),
        .TICK_CYCLES (TICK),
        .ARM_CYCLES  (ARM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .boot_req (boot_req),
        .abort    (abort),
        .wb_s1    (wb_s1),
        .wb_s0    (wb_s0),
        .wb_boot  (wb_boot),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // BRAM read side: output updates one cycle after rd_en and holds otherwise
    always @(posedge clk) if (rd_en) rd_data <= bram_word;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_fetch(output int c0);
        bit found = 1'b0;
        c0 = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (rd_en === 1'b1) begin
                found = 1'b1;
                c0 = cyc;
            end
        end
        check("rd_en_pulse", 32'(found), 1);
    endtask

    task automatic push_boot(input int at, input logic s1, input logic s0);
        exp_t e;
        e.boot_cyc = at;
        e.s1 = s1;
        e.s0 = s0;
        sb.push_back(e);
    endtask

    task automatic expect_boot(input int bound);
        exp_t e;
        bit found = 1'b0;
        int at = -1;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (wb_boot === 1'b1) begin
                found = 1'b1;
                at = cyc;
            end
        end
        e = sb.pop_front();
        check("boot_rise", 32'(found), 1);
        check("boot_cycle", at, e.boot_cyc);
        check("boot_s1", 32'(wb_s1), 32'(e.s1));
        check("boot_s0", 32'(wb_s0), 32'(e.s0));
    endtask

    task automatic do_reset(input logic [15:0] word);
        bram_word = word;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int c0, c1, k;
        bit acc_boot, acc_rd;

        // Reset values
        bram_word = 16'hA003;
        repeat (3) @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 1);
        check("rst_s1", 32'(wb_s1), 0);
        check("rst_s0", 32'(wb_s0), 0);
        check("rst_boot", 32'(wb_boot), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);

        // 1: valid, sel=01, dwell=3 -> ARM at c15, BOOT at c17
        rst_n = 1'b1;
        wait_fetch(c0);
        check("s1_busy_c0", 32'(busy), 1);
        goto(c0 + 1);
        check("s1_rd_en_one_cycle", 32'(rd_en), 0);
        push_boot(c0 + 3 + 3 * TICK + ARM, 1'b0, 1'b1);
        goto(c0 + 14);
        check("s1_count_len_s0", 32'(wb_s0), 0);
        goto(c0 + 15);
        check("s1_arm_s1", 32'(wb_s1), 0);
        check("s1_arm_s0", 32'(wb_s0), 1);
        check("s1_arm_noboot", 32'(wb_boot), 0);
        expect_boot(6);
        repeat (5) @(negedge clk);
        check("s1_boot_held", 32'(wb_boot), 1);
        check("s1_busy_fire", 32'(busy), 1);

        // 2: invalid word -> HALT at c3
        do_reset(16'h4005);
        wait_fetch(c0);
        goto(c0 + 2);
        check("s2_err_c2", 32'(err), 0);
        check("s2_busy_c2", 32'(busy), 1);
        goto(c0 + 3);
        check("s2_err_c3", 32'(err), 1);
        check("s2_busy_c3", 32'(busy), 0);
        acc_boot = 1'b0;
        acc_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            acc_boot |= wb_boot;
            acc_rd |= rd_en;
        end
        check("s2_no_boot", 32'(acc_boot), 0);
        check("s2_no_refetch", 32'(acc_rd), 0);

        // 3: dwell=0 waits forever; boot_req forces ARM
        do_reset(16'hE000);
        wait_fetch(c0);
        goto(c0 + 3 + 1000);
        check("s3_no_autoboot", 32'(wb_boot), 0);
        check("s3_busy", 32'(busy), 1);
        check("s3_s1_idle", 32'(wb_s1), 0);
        boot_req = 1'b1;
        k = cyc;
        push_boot(k + 1 + ARM, 1'b1, 1'b1);
        @(negedge clk);
        boot_req = 1'b0;
        check("s3_arm_s1", 32'(wb_s1), 1);
        check("s3_arm_s0", 32'(wb_s0), 1);
        check("s3_arm_noboot", 32'(wb_boot), 0);
        expect_boot(6);

        // 4: abort in COUNT cycle 5 re-fetches a new word (sel=10, dwell=1)
        do_reset(16'hA00A);
        wait_fetch(c0);
        goto(c0 + 4);
        bram_word = 16'hC001;
        goto(c0 + 8);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s4_abort_refetch", 32'(rd_en), 1);
        c1 = cyc;
        push_boot(c1 + 3 + TICK + ARM, 1'b1, 1'b0);
        goto(c1 + 6);
        check("s4_pre_arm_s1", 32'(wb_s1), 0);
        goto(c1 + 7);
        check("s4_arm_s1", 32'(wb_s1), 1);
        check("s4_arm_s0", 32'(wb_s0), 0);
        expect_boot(6);

        // 5: abort beats boot_req; abort during FIRE ignored
        do_reset(16'hA003);
        wait_fetch(c0);
        goto(c0 + 5);
        abort = 1'b1;
        boot_req = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        boot_req = 1'b0;
        check("s5_abort_wins_rd", 32'(rd_en), 1);
        check("s5_abort_wins_s0", 32'(wb_s0), 0);
        c1 = cyc;
        push_boot(c1 + 3 + 3 * TICK + ARM, 1'b0, 1'b1);
        expect_boot(24);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_fire_abort_boot", 32'(wb_boot), 1);
        check("s5_fire_abort_rd", 32'(rd_en), 0);
        abort = 1'b0;

        // 6: reset in ARM and FIRE, plus abort in ARM (sel=01, dwell=1)
        do_reset(16'hA001);
        wait_fetch(c0);
        goto(c0 + 3 + TICK);
        check("s6_arm_s0", 32'(wb_s0), 1);
        #2 rst_n = 1'b0;
        #1;
        check("s6_arm_rst_s0", 32'(wb_s0), 0);
        check("s6_arm_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch(c0);
        goto(c0 + 3 + TICK);
        check("s6_rearm_s0", 32'(wb_s0), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("s6_arm_abort_s0", 32'(wb_s0), 0);
        check("s6_arm_abort_rd", 32'(rd_en), 1);
        c1 = cyc;
        push_boot(c1 + 3 + TICK + ARM, 1'b0, 1'b1);
        expect_boot(12);
        #2 rst_n = 1'b0;
        #1;
        check("s6_fire_rst_boot", 32'(wb_boot), 0);
        check("s6_fire_rst_s0", 32'(wb_s0), 0);
        check("s6_fire_rst_busy", 32'(busy), 0);
        check("s6_fire_rst_rd", 32'(rd_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch(c0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
